// File: rtl/tile_level_loader.sv
// Write-port sequencer for the 8x8 tile array: bulk level loads from a constant
// table (one cell per clock) and req/ack single-cell updates between loads.
module tile_level_loader #(
  parameter int unsigned COLS = 8,
  parameter int unsigned ROWS = 8
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startLoad,
  input  logic [1:0]  levelSel,
  input  logic        updReq,
  input  logic [2:0]  updX,
  input  logic [2:0]  updY,
  input  logic [1:0]  updType,
  output logic        updAck,
  output logic        writeEn,
  output logic [10:0] TargetX,
  output logic [10:0] TargetY,
  output logic [1:0]  Write_Tile_type,
  output logic        busy,
  output logic        loadDone
);

  localparam int unsigned XW = $clog2(COLS);
  localparam int unsigned YW = $clog2(ROWS);
  localparam int unsigned CW = XW + YW;
  localparam logic [XW-1:0] X_LAST     = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_VIS_LAST = YW'(ROWS - 3);
  localparam logic [CW-1:0] CNT_LAST   = CW'(COLS * ROWS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE,
    ST_UPD,
    ST_REL
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  lvl_q, lvl_d;
  logic        write_en_q, write_en_d;
  logic        upd_ack_q, upd_ack_d;
  logic [10:0] target_x_q, target_x_d;
  logic [10:0] target_y_q, target_y_d;
  logic [1:0]  tile_type_q, tile_type_d;
  logic        busy_q, busy_d;
  logic        load_done_q, load_done_d;

  logic [XW-1:0] cnt_x;
  logic [YW-1:0] cnt_y;

  assign cnt_x = cnt_q[XW-1:0];
  assign cnt_y = cnt_q[CW-1:XW];

  // Rows below the visible area stay empty; the visible area is walled in.
  function automatic logic [1:0] level_tile(input logic [1:0] lvl,
                                            input logic [XW-1:0] x,
                                            input logic [YW-1:0] y);
    logic [1:0] t;
    t = 2'b00;
    if (y <= Y_VIS_LAST) begin
      if (x == '0 || x == X_LAST || y == '0 || y == Y_VIS_LAST) begin
        t = 2'b01;
      end else begin
        if (lvl != 2'd0 && x == XW'(6) && y == YW'(4)) t = 2'b10;
        if (lvl == 2'd2 && x == XW'(3) && y == YW'(2)) t = 2'b11;
        if (lvl == 2'd3 && y == YW'(3) && x <= XW'(5)) t = 2'b01;
      end
    end
    return t;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lvl_d       = lvl_q;
    write_en_d  = 1'b0;
    upd_ack_d   = 1'b0;
    busy_d      = 1'b0;
    load_done_d = 1'b0;
    target_x_d  = target_x_q;
    target_y_d  = target_y_q;
    tile_type_d = tile_type_q;

    case (state_q)
      ST_IDLE: begin
        if (startLoad) begin
          state_d = ST_LOAD;
          lvl_d   = levelSel;
          cnt_d   = '0;
        end else if (updReq) begin
          state_d = ST_UPD;
        end
      end
      ST_LOAD: begin
        write_en_d  = 1'b1;
        busy_d      = 1'b1;
        target_x_d  = 11'(cnt_x);
        target_y_d  = 11'(cnt_y);
        tile_type_d = level_tile(lvl_q, cnt_x, cnt_y);
        cnt_d       = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end
      end
      ST_DONE: begin
        busy_d      = 1'b1;
        load_done_d = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_UPD: begin
        write_en_d  = 1'b1;
        upd_ack_d   = 1'b1;
        target_x_d  = 11'(updX);
        target_y_d  = 11'(updY);
        tile_type_d = updType;
        state_d     = ST_REL;
      end
      ST_REL: begin
        // Wait for the requester to drop updReq so one request gives one write.
        if (!updReq) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      lvl_q       <= '0;
      write_en_q  <= 1'b0;
      upd_ack_q   <= 1'b0;
      target_x_q  <= '0;
      target_y_q  <= '0;
      tile_type_q <= '0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lvl_q       <= lvl_d;
      write_en_q  <= write_en_d;
      upd_ack_q   <= upd_ack_d;
      target_x_q  <= target_x_d;
      target_y_q  <= target_y_d;
      tile_type_q <= tile_type_d;
      busy_q      <= busy_d;
      load_done_q <= load_done_d;
    end
  end

  assign writeEn         = write_en_q;
  assign updAck          = upd_ack_q;
  assign TargetX         = target_x_q;
  assign TargetY         = target_y_q;
  assign Write_Tile_type = tile_type_q;
  assign busy            = busy_q;
  assign loadDone        = load_done_q;

endmodule

// File: tb/tb_tile_level_loader.sv
// Self-checking bench for tile_level_loader: directed loads/updates, constant
// cell expectations, and randomized traffic against a painted level map model.
module tb_tile_level_loader;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startLoad;
  logic [1:0]  levelSel;
  logic        updReq;
  logic [2:0]  updX, updY;
  logic [1:0]  updType;
  logic        updAck, writeEn, busy, loadDone;
  logic [10:0] TargetX, TargetY;
  logic [1:0]  Write_Tile_type;

  tile_level_loader #(.COLS(8), .ROWS(8)) dut (
    .clk(clk), .resetN(resetN), .startLoad(startLoad), .levelSel(levelSel),
    .updReq(updReq), .updX(updX), .updY(updY), .updType(updType),
    .updAck(updAck), .writeEn(writeEn), .TargetX(TargetX), .TargetY(TargetY),
    .Write_Tile_type(Write_Tile_type), .busy(busy), .loadDone(loadDone)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [1:0]  ref_map [4][8][8];
  logic [1:0]  cap     [4][8][8];

  typedef struct { int lvl; int x; int y; logic [1:0] t; } cell_vec_t;
  typedef struct { logic [2:0] x; logic [2:0] y; logic [1:0] t; int hold; } upd_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: paint each level as a picture, then add that level's features.
  task automatic build_model();
    for (int l = 0; l < 4; l++)
      for (int y = 0; y < 8; y++)
        for (int x = 0; x < 8; x++) begin
          ref_map[l][y][x] = 2'd0;
          cap[l][y][x]     = 2'bxx;
          if (y <= 5 && (y == 0 || y == 5 || x == 0 || x == 7)) ref_map[l][y][x] = 2'd1;
        end
    for (int l = 1; l < 4; l++) ref_map[l][4][6] = 2'd2;
    ref_map[2][2][3] = 2'd3;
    for (int x = 1; x <= 5; x++) ref_map[3][3][x] = 2'd1;
  endtask

  // Caller leaves the DUT in IDLE; returns two cycles after DONE.
  task automatic do_load(input int lvl, input int chg_at, input int chg_lvl, input int repulse_at);
    startLoad = 1'b1;
    levelSel  = 2'(lvl);
    tick();
    chk("load_e0_we", writeEn, 0);
    chk("load_e0_busy", busy, 0);
    startLoad = 1'b0;
    if (chg_at < 0) levelSel = 2'($urandom);
    for (int k = 0; k < 64; k++) begin
      tick();
      chk("load_we", writeEn, 1);
      chk("load_busy", busy, 1);
      chk("load_done_early", loadDone, 0);
      chk("load_x", TargetX, k % 8);
      chk("load_y", TargetY, k / 8);
      chk("load_type", Write_Tile_type, ref_map[lvl][k / 8][k % 8]);
      cap[lvl][TargetY[2:0]][TargetX[2:0]] = Write_Tile_type;
      startLoad = (k == repulse_at);
      if (k == chg_at) levelSel = 2'(chg_lvl);
    end
    startLoad = 1'b0;
    tick();
    chk("e65_we", writeEn, 0);
    chk("e65_done", loadDone, 1);
    chk("e65_busy", busy, 1);
    tick();
    chk("e66_busy", busy, 0);
    chk("e66_done", loadDone, 0);
    chk("e66_we", writeEn, 0);
  endtask

  task automatic do_upd(input logic [2:0] x, input logic [2:0] y, input logic [1:0] t,
                        input int hold, input bit pulse_start);
    updReq = 1'b1; updX = x; updY = y; updType = t;
    tick();
    chk("upd_e0_we", writeEn, 0);
    chk("upd_e0_ack", updAck, 0);
    tick();
    chk("upd_we", writeEn, 1);
    chk("upd_ack", updAck, 1);
    chk("upd_x", TargetX, {8'd0, x});
    chk("upd_y", TargetY, {8'd0, y});
    chk("upd_type", Write_Tile_type, t);
    chk("upd_busy", busy, 0);
    for (int i = 2; i < hold; i++) begin
      startLoad = pulse_start && (i == 2);
      tick();
      chk("rel_we", writeEn, 0);
      chk("rel_ack", updAck, 0);
      chk("rel_x_hold", TargetX, {8'd0, x});
      chk("rel_type_hold", Write_Tile_type, t);
    end
    startLoad = 1'b0;
    updReq = 1'b0;
    updX = 3'($urandom); updY = 3'($urandom); updType = 2'($urandom);
    tick();
    chk("drop_we", writeEn, 0);
    chk("drop_busy", busy, 0);
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("idle_we", writeEn, 0);
      chk("idle_busy", busy, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    cell_vec_t cells[14];
    upd_vec_t  upds[5];

    cells = '{
      '{1, 0, 0, 2'd1}, '{1, 6, 4, 2'd2}, '{1, 3, 3, 2'd0}, '{1, 2, 7, 2'd0},
      '{1, 7, 5, 2'd1}, '{3, 1, 3, 2'd1}, '{3, 3, 3, 2'd1}, '{3, 5, 3, 2'd1},
      '{3, 6, 4, 2'd2}, '{3, 6, 3, 2'd0}, '{2, 3, 2, 2'd3}, '{2, 6, 4, 2'd2},
      '{0, 6, 4, 2'd0}, '{0, 4, 6, 2'd0}
    };
    upds = '{
      '{3'd3, 3'd2, 2'd3, 5}, '{3'd0, 3'd0, 2'd0, 2}, '{3'd7, 3'd7, 2'd1, 3},
      '{3'd7, 3'd0, 2'd2, 4}, '{3'd0, 3'd7, 2'd3, 2}
    };

    build_model();
    resetN = 1'b0; startLoad = 1'b0; levelSel = 2'd0;
    updReq = 1'b0; updX = 3'd0; updY = 3'd0; updType = 2'd0;
    #1;
    chk("rst_we", writeEn, 0);
    chk("rst_ack", updAck, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", loadDone, 0);
    chk("rst_x", TargetX, 0);
    chk("rst_y", TargetY, 0);
    chk("rst_type", Write_Tile_type, 0);
    @(negedge clk);
    resetN = 1'b1;
    idle_check(2);

    do_load(1, -1, 0, -1);
    idle_check(2);

    foreach (upds[i]) do_upd(upds[i].x, upds[i].y, upds[i].t, upds[i].hold, 1'b0);

    // Load and update requested on the same edge: load first, update kept.
    updReq = 1'b1; updX = 3'd5; updY = 3'd1; updType = 2'd2;
    do_load(0, -1, 0, -1);
    tick();
    chk("pend_we", writeEn, 1);
    chk("pend_ack", updAck, 1);
    chk("pend_x", TargetX, 5);
    chk("pend_y", TargetY, 1);
    chk("pend_type", Write_Tile_type, 2);
    updReq = 1'b0;
    idle_check(3);

    do_load(1, -1, 0, 20);
    idle_check(3);

    do_load(3, 10, 0, -1);
    idle_check(1);

    // Reset at load cycle 30 aborts immediately.
    startLoad = 1'b1; levelSel = 2'd2;
    tick();
    startLoad = 1'b0;
    for (int k = 0; k < 30; k++) tick();
    chk("pre_rst_we", writeEn, 1);
    resetN = 1'b0;
    #1;
    chk("mid_rst_we", writeEn, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_x", TargetX, 0);
    chk("mid_rst_y", TargetY, 0);
    chk("mid_rst_type", Write_Tile_type, 0);
    @(negedge clk);
    resetN = 1'b1;
    idle_check(5);
    do_load(2, -1, 0, -1);

    foreach (cells[i])
      chk($sformatf("cell_l%0d_%0d_%0d", cells[i].lvl, cells[i].x, cells[i].y),
          cap[cells[i].lvl][cells[i].y][cells[i].x], cells[i].t);

    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        int l;
        l = $urandom_range(0, 3);
        do_load(l, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 62) : -1,
                $urandom_range(0, 3), ($urandom_range(0, 1) == 1) ? $urandom_range(0, 62) : -1);
      end else begin
        do_upd(3'($urandom), 3'($urandom), 2'($urandom), $urandom_range(2, 6),
               1'($urandom_range(0, 1)));
      end
      idle_check($urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
